// File: rtl/pcs_tx_sequencer.sv
// rtl/pcs_tx_sequencer.sv - transmit ordered-set sequencer feeding the 8b/10b encoder
// Optional feature macro: PCS_TX_ERR_PROP_EN (adds tx_er, emits /V/ for errored bytes)
module pcs_tx_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic [7:0]       txd,
`ifdef PCS_TX_ERR_PROP_EN
  input  logic             tx_er,
`endif
  output logic             tx_ready,
  input  logic             rd_in,
  output logic [7:0]       enc_data,
  output logic             enc_is_k,
  output logic             enc_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE_K,
    S_IDLE_D,
    S_START,
    S_DATA,
    S_END_T,
    S_END_R,
    S_END_R2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] data_next;
  logic       k_next;
  logic       valid_next;
  logic       cnt_inc;
  logic       parity;     // slot of the group being output: 0 = even, 1 = odd
  logic       xfer;
  logic       err;

`ifdef PCS_TX_ERR_PROP_EN
  assign err = tx_er;
`else
  assign err = 1'b0;
`endif

  // Source may hand over a byte only while a data-carrying slot is next
  always_comb begin
    tx_ready = (state == S_IDLE_D) || (state == S_START) || (state == S_DATA);
  end

  assign xfer = tx_en && tx_ready;

  // Next state together with the code group it will present
  always_comb begin
    state_next = S_IDLE_K;
    data_next  = K28_5;
    k_next     = 1'b1;
    valid_next = 1'b1;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE_K: begin
        // Disparity of the K28.5 now on the wire picks /I1/ or /I2/
        state_next = S_IDLE_D;
        data_next  = rd_in ? D5_6 : D16_2;
        k_next     = 1'b0;
      end
      S_IDLE_D: begin
        if (xfer) begin
          // Preamble byte is swallowed and replaced by /S/
          state_next = S_START;
          data_next  = err ? K30_7 : K27_7;
          k_next     = 1'b1;
        end
      end
      S_START, S_DATA: begin
        if (xfer) begin
          state_next = S_DATA;
          data_next  = err ? K30_7 : txd;
          k_next     = err;
        end else begin
          state_next = S_END_T;
          data_next  = K29_7;
          k_next     = 1'b1;
          cnt_inc    = 1'b1;
        end
      end
      S_END_T: begin
        state_next = S_END_R;
        data_next  = K23_7;
      end
      S_END_R: begin
        // An /R/ on an even slot needs a second /R/ so idles restart even
        if (!parity) begin
          state_next = S_END_R2;
          data_next  = K23_7;
        end
      end
      S_END_R2: begin
        state_next = S_IDLE_K;
      end
      default: begin
        state_next = S_IDLE_K;
      end
    endcase
  end

  // Registered state, outputs, slot parity and saturating frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RESET;
      enc_data  <= 8'h00;
      enc_is_k  <= 1'b0;
      enc_valid <= 1'b0;
      parity    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      enc_data  <= data_next;
      enc_is_k  <= k_next;
      enc_valid <= valid_next;
      if (enc_valid) begin
        parity <= ~parity;
      end
      if (cnt_inc && (frame_cnt != {CNT_W{1'b1}})) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// tb/tb_pcs_tx_sequencer.sv - self-checking bench for pcs_tx_sequencer
module tb_pcs_tx_sequencer;

  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             tx_en;
  logic [7:0]       txd;
  logic             tx_ready;
  logic             rd_in;
  logic [7:0]       enc_data;
  logic             enc_is_k;
  logic             enc_valid;
  logic [CNT_W-1:0] frame_cnt;
`ifdef PCS_TX_ERR_PROP_EN
  logic             tx_er;
`endif

  pcs_tx_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_en     (tx_en),
    .txd       (txd),
`ifdef PCS_TX_ERR_PROP_EN
    .tx_er     (tx_er),
`endif
    .tx_ready  (tx_ready),
    .rd_in     (rd_in),
    .enc_data  (enc_data),
    .enc_is_k  (enc_is_k),
    .enc_valid (enc_valid),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model: expected current group, slot index since reset,
  // frame/tail flags and a queue of pending end-of-frame groups
  logic [7:0] m_data;
  logic       m_k;
  logic       m_valid;
  logic       m_in_frame;
  logic       m_tail;
  int         m_slot;
  int         m_cnt;
  logic [7:0] tq[$];
  logic [7:0] fb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check the present cycle, drive inputs, advance model one group
  task automatic step(input logic en_i, input logic [7:0] d_i, input logic rd_i,
                      input logic rst_i, output logic xf);
    logic exp_rdy;
    int   os;
    exp_rdy = m_valid && !m_tail && (m_in_frame || (m_slot % 2 == 1));
    chk("enc_valid", {31'b0, enc_valid}, {31'b0, m_valid});
    chk("enc_data", {24'b0, enc_data}, {24'b0, m_data});
    chk("enc_is_k", {31'b0, enc_is_k}, {31'b0, m_k});
    chk("tx_ready", {31'b0, tx_ready}, {31'b0, exp_rdy});
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    reset = rst_i;
    tx_en = en_i;
    txd   = d_i;
    rd_in = rd_i;
    xf = en_i && exp_rdy && !rst_i;
    if (rst_i) begin
      m_valid = 1'b0; m_data = 8'h00; m_k = 1'b0; m_slot = 0; m_cnt = 0;
      m_in_frame = 1'b0; m_tail = 1'b0; tq.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1; m_data = 8'hBC; m_k = 1'b1; m_slot = 0;
    end else begin
      os = m_slot;
      m_slot = m_slot + 1;
      if (tq.size() > 0) begin
        m_data = tq.pop_front(); m_k = 1'b1; m_tail = 1'b1;
      end else if (m_in_frame) begin
        if (en_i) begin
          m_data = d_i; m_k = 1'b0;
        end else begin
          m_data = 8'hFD; m_k = 1'b1; m_in_frame = 1'b0; m_tail = 1'b1;
          tq.push_back(8'hF7);
          if ((m_slot + 1) % 2 == 0) tq.push_back(8'hF7);
          if (m_cnt < CMAX) m_cnt++;
        end
      end else if (m_tail) begin
        m_data = 8'hBC; m_k = 1'b1; m_tail = 1'b0;
      end else if (os % 2 == 0) begin
        m_data = rd_i ? 8'hC5 : 8'h50; m_k = 1'b0;
      end else if (en_i) begin
        m_data = 8'hFB; m_k = 1'b1; m_in_frame = 1'b1;
      end else begin
        m_data = 8'hBC; m_k = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int rd_mode);
    logic xf;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, (rd_mode > 1) ? 1'($urandom_range(0, 1)) : 1'(rd_mode), 1'b0, xf);
    end
  endtask

  // Offer fb[] as one frame with tx_en held; abort_at >= 0 pulses reset after that many transfers
  task automatic send_frame(input int gap, input int abort_at);
    logic xf;
    int   idx;
    int   guard;
    idle(gap, 2);
    idx = 0;
    guard = 0;
    while (idx < fb.size() && guard < 40) begin
      if (idx == abort_at) begin
        step(1'b1, fb[idx], 1'b0, 1'b1, xf);
        break;
      end
      step(1'b1, fb[idx], 1'($urandom_range(0, 1)), 1'b0, xf);
      if (xf) idx++;
      guard++;
    end
    n_cmp++;
    if (guard >= 40) begin
      n_fail++;
      $error("FAIL frame_accept observed=%0d expected=%0d", idx, fb.size());
    end
  endtask

  initial begin
    logic xf;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; tx_en = 1'b0; txd = 8'h00; rd_in = 1'b0;
`ifdef PCS_TX_ERR_PROP_EN
    tx_er = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0; m_data = 8'h00; m_k = 1'b0; m_slot = 0; m_cnt = 0;
    m_in_frame = 1'b0; m_tail = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1, xf);

    idle(6, 0);
    idle(6, 1);
    idle(4, 0);

    fb = '{8'h55, 8'hA1, 8'hA2, 8'hA3};
    send_frame(0, -1);
    fb = '{8'h55, 8'hB0, 8'hB1};
    send_frame(0, -1);
    fb = '{8'h55};
    send_frame(1, -1);
    fb = '{8'h55, 8'h11};
    send_frame(0, -1);
    idle(6, 2);

    fb = '{8'h55, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    send_frame(2, 3);
    idle(5, 2);

    for (int f = 0; f < 30; f++) begin
      fb.delete();
      fb.push_back(8'h55);
      for (int b = 0; b < $urandom_range(0, 7); b++) fb.push_back(8'($urandom));
      send_frame($urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 2 : -1);
    end
    idle(8, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
